// File: rtl/pattern_bit_serializer.sv
// Parallel-to-serial feeder for the pattern detector: one bit per clock on d_o/valid_o.
// First bit follows the accepting edge; a one-word hold register keeps back-to-back words gapless, ready drops only while it is full.
module pattern_bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_i,
   input  logic             data_valid_i,
   output logic             data_ready_o,
   input  logic             abort_i,
   output logic             d_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] words_sent_o
);

   localparam int BC_W = $clog2(WIDTH + 1);
   localparam logic [BC_W-1:0] FULL_CNT = BC_W'(WIDTH);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] r_hold;
   logic [WIDTH-1:0] w_hold_nxt;
   logic [BC_W-1:0]  r_cnt;
   logic [BC_W-1:0]  w_cnt_nxt;
   logic             r_hold_full;
   logic             w_hold_full_nxt;
   logic [CNT_W-1:0] r_words;
   logic [CNT_W-1:0] w_words_nxt;
   logic             w_accept;
   logic             w_last;
   logic             w_valid;

   // Ready depends only on the hold register, never on data_valid_i.
   assign data_ready_o = ~r_hold_full;
   assign w_accept     = data_valid_i & ~r_hold_full;
   assign w_last       = (r_cnt == BC_W'(1));
   assign w_shifted    = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_cnt_nxt       = r_cnt;
      w_hold_nxt      = r_hold;
      w_hold_full_nxt = r_hold_full;
      w_words_nxt     = r_words;
      if (abort_i) begin
         // Flush everything in flight, including a word accepted this cycle; keep the count.
         w_state_nxt     = S_IDLE;
         w_shift_nxt     = '0;
         w_cnt_nxt       = '0;
         w_hold_nxt      = '0;
         w_hold_full_nxt = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  w_shift_nxt = data_i;
                  w_cnt_nxt   = FULL_CNT;
                  w_state_nxt = S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (!w_last) begin
                  w_shift_nxt = w_shifted;
                  w_cnt_nxt   = r_cnt - 1'b1;
                  if (w_accept) begin
                     w_hold_nxt      = data_i;
                     w_hold_full_nxt = 1'b1;
                  end
               end else begin
                  w_words_nxt = r_words + 1'b1;
                  if (r_hold_full) begin
                     w_shift_nxt     = r_hold;
                     w_cnt_nxt       = FULL_CNT;
                     w_hold_nxt      = '0;
                     w_hold_full_nxt = 1'b0;
                  end else if (w_accept) begin
                     w_shift_nxt = data_i;
                     w_cnt_nxt   = FULL_CNT;
                  end else begin
                     w_shift_nxt = '0;
                     w_cnt_nxt   = '0;
                     w_state_nxt = S_IDLE;
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_words     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_cnt       <= w_cnt_nxt;
         r_hold      <= w_hold_nxt;
         r_hold_full <= w_hold_full_nxt;
         r_words     <= w_words_nxt;
      end
   end

   assign w_valid      = (r_state == S_SHIFT);
   assign valid_o      = w_valid;
   assign d_o          = w_valid & (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]);
   assign busy_o       = w_valid | r_hold_full;
   assign words_sent_o = r_words;

endmodule

// File: tb/tb_pattern_bit_serializer.sv
// Directed bench for pattern_bit_serializer: MSB-first, LSB-first and 2-bit-counter instances share one stimulus.
module tb_pattern_bit_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_i;
   logic        data_valid_i;
   logic        abort_i;

   logic        rdy0, d0, v0, busy0;
   logic [15:0] words0;
   logic        rdy1, d1, v1, busy1;
   logic [15:0] words1;
   logic        rdy2, d2, v2, busy2;
   logic [1:0]  words2;

   int          errors = 0;
   int          checks = 0;
   bit          exp_q[$];
   logic [7:0]  pat;
   logic [7:0]  b2b [3];
   logic        eb;
   bit          acc;
   int          nacc, run, vfirst, vlast, ready_lo, bit_err;

   always #5 clk = ~clk;

   pattern_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .data_i(data_i), .data_valid_i(data_valid_i),
      .data_ready_o(rdy0), .abort_i(abort_i), .d_o(d0), .valid_o(v0),
      .busy_o(busy0), .words_sent_o(words0));

   pattern_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .data_i(data_i), .data_valid_i(data_valid_i),
      .data_ready_o(rdy1), .abort_i(abort_i), .d_o(d1), .valid_o(v1),
      .busy_o(busy1), .words_sent_o(words1));

   pattern_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .data_i(data_i), .data_valid_i(data_valid_i),
      .data_ready_o(rdy2), .abort_i(abort_i), .d_o(d2), .valid_o(v2),
      .busy_o(busy2), .words_sent_o(words2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst          = 1'b1;
      data_i       = '0;
      data_valid_i = 1'b0;
      abort_i      = 1'b0;
      #12;
      chk("rst_valid", v0, 1'b0);
      chk("rst_d", d0, 1'b0);
      chk("rst_ready", rdy0, 1'b1);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_words", words0, 16'd0);
      rst = 1'b0;
      tick;

      // Single word, both bit orders
      pat          = 8'hB4;
      data_i       = pat;
      data_valid_i = 1'b1;
      tick;
      data_valid_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("single_valid_msb", v0, 1'b1);
         chk("single_valid_lsb", v1, 1'b1);
         chk("single_bit_msb", d0, pat[7-i]);
         chk("single_bit_lsb", d1, pat[i]);
         tick;
      end
      chk("single_end_valid", v0, 1'b0);
      chk("single_end_busy", busy0, 1'b0);
      chk("single_end_ready", rdy0, 1'b1);
      chk("single_words_msb", words0, 16'd1);
      chk("single_words_lsb", words1, 16'd1);

      // Back-to-back words with the source holding valid
      b2b[0] = 8'hA5; b2b[1] = 8'h3C; b2b[2] = 8'hFF;
      nacc = 0; run = 0; vfirst = -1; vlast = -1; ready_lo = 0;
      data_i       = b2b[0];
      data_valid_i = 1'b1;
      for (int c = 0; c < 40; c++) begin
         acc = data_valid_i & rdy0;
         tick;
         if (acc) begin
            for (int b = 7; b >= 0; b--) exp_q.push_back(data_i[b]);
            nacc++;
            if (nacc < 3) data_i = b2b[nacc];
            else data_valid_i = 1'b0;
            if (nacc == 2) chk("b2b_ready_low_after_2nd", rdy0, 1'b0);
         end
         if (v0) begin
            run++;
            if (vfirst < 0) vfirst = c;
            vlast = c;
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : ~d0;
            chk("b2b_bit", d0, eb);
         end
         if (!rdy0) ready_lo++;
      end
      chk("b2b_valid_cycles", run, 24);
      chk("b2b_valid_span", vlast - vfirst + 1, 24);
      chk("b2b_ready_low_cycles", ready_lo, 14);
      chk("b2b_accepts", nacc, 3);
      chk("b2b_words", words0, 16'd4);
      chk("b2b_words_wrap", words2, 2'd0);
      chk("b2b_busy_end", busy0, 1'b0);
      chk("b2b_ready_end", rdy0, 1'b1);

      // Asynchronous reset in the middle of a word
      pat          = 8'h5A;
      data_i       = pat;
      data_valid_i = 1'b1;
      tick;
      data_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("arst_pre_bit", d0, pat[7-i]);
         tick;
      end
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", v0, 1'b0);
      chk("arst_d", d0, 1'b0);
      chk("arst_valid_lsb", v1, 1'b0);
      chk("arst_words", words0, 16'd0);
      chk("arst_ready", rdy0, 1'b1);
      chk("arst_busy", busy0, 1'b0);
      #2;
      rst = 1'b0;
      tick;
      pat          = 8'hC3;
      data_i       = pat;
      data_valid_i = 1'b1;
      tick;
      data_valid_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("post_rst_valid", v0, 1'b1);
         chk("post_rst_bit_msb", d0, pat[7-i]);
         chk("post_rst_bit_lsb", d1, pat[i]);
         tick;
      end
      chk("post_rst_words", words0, 16'd1);
      chk("post_rst_idle", v0, 1'b0);

      // Abort with the hold register full
      data_i       = 8'h81;
      data_valid_i = 1'b1;
      tick;
      data_i = 8'h7E;
      tick;
      data_valid_i = 1'b0;
      chk("abort_hold_full_ready", rdy0, 1'b0);
      tick;
      abort_i = 1'b1;
      tick;
      abort_i = 1'b0;
      chk("abort_valid", v0, 1'b0);
      chk("abort_d", d0, 1'b0);
      chk("abort_busy", busy0, 1'b0);
      chk("abort_ready", rdy0, 1'b1);
      chk("abort_words_kept", words0, 16'd1);
      run = 0;
      for (int c = 0; c < 20; c++) begin
         if (v0) run++;
         tick;
      end
      chk("abort_no_leftover_bits", run, 0);
      // Word offered in the abort cycle is dropped even though ready was high
      data_i       = 8'hFF;
      data_valid_i = 1'b1;
      abort_i      = 1'b1;
      tick;
      data_valid_i = 1'b0;
      abort_i      = 1'b0;
      chk("abort_drop_valid", v0, 1'b0);
      chk("abort_drop_busy", busy0, 1'b0);
      chk("abort_drop_words", words0, 16'd1);

      // Long random stream, source always valid
      rst = 1'b1;
      #3;
      rst = 1'b0;
      tick;
      exp_q.delete();
      nacc = 0; run = 0; bit_err = 0;
      data_i       = 8'($urandom);
      data_valid_i = 1'b1;
      for (int c = 0; c < 6000; c++) begin
         acc = data_valid_i & rdy0;
         tick;
         if (acc) begin
            for (int b = 7; b >= 0; b--) exp_q.push_back(data_i[b]);
            nacc++;
            if (nacc < 600) data_i = 8'($urandom_range(0, 255));
            else data_valid_i = 1'b0;
         end
         if (v0) begin
            run++;
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : ~d0;
            if (d0 !== eb) bit_err++;
         end
         if (nacc >= 600 && !v0 && !busy0) break;
      end
      chk("rand_accepts", nacc, 600);
      chk("rand_valid_cycles", run, 4800);
      chk("rand_bit_errors", bit_err, 0);
      chk("rand_leftover_bits", exp_q.size(), 0);
      chk("rand_words", words0, 16'd600);
      chk("rand_words_wrap", words2, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
